// File: rtl/bch_pkg.sv
// Shared definitions for the BCH(542,512) decoder over GF(2^10).
// Holds the code parameters, the field polynomial, element types, the FSM
// state type and the GF helper functions used by the Chien search stage.
// No ports: package only.
package bch_pkg;

   localparam int BCH_M      = 10;                   // symbol width, GF(2^M)
   localparam int BCH_N      = 542;                  // codeword length in bits
   localparam int BCH_T      = 3;                    // max correctable errors
   localparam int BCH_P      = 8;                    // positions per cycle
   localparam int BCH_CHUNKS = (BCH_N + BCH_P - 1) / BCH_P;
   localparam int IDX_W      = 7;                    // chunk index width
   localparam int CNT_W      = 10;                   // root counter width
   localparam int GF_ORDER   = (1 << BCH_M) - 1;     // multiplicative order
   localparam logic [BCH_M:0] GF_POLY = 11'h409;     // x^10 + x^3 + 1

   typedef logic [BCH_M-1:0]   gf_elem_t;
   typedef gf_elem_t [BCH_T:0] gf_vec_t;
   typedef logic [BCH_P-1:0]   chunk_t;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_SEARCH = 1'b1
   } state_e;

   // x * alpha: shift up one power, fold x^M back through the polynomial.
   function automatic gf_elem_t gf_mul_alpha(gf_elem_t x);
      gf_elem_t y;
      y = {x[BCH_M-2:0], 1'b0};
      if (x[BCH_M-1]) y = y ^ GF_POLY[BCH_M-1:0];
      return y;
   endfunction

   // General product by shift-and-add. With one operand constant this
   // collapses to a fixed XOR matrix.
   function automatic gf_elem_t gf_mul(gf_elem_t a, gf_elem_t b);
      gf_elem_t acc;
      acc = '0;
      for (int i = BCH_M - 1; i >= 0; i--) begin
         acc = gf_mul_alpha(acc);
         if (b[i]) acc = acc ^ a;
      end
      return acc;
   endfunction

   // alpha^e by square-and-multiply; exponent reduced mod the field order.
   function automatic gf_elem_t gf_pow_alpha(int e);
      int       ee;
      gf_elem_t res;
      gf_elem_t base;
      ee = e % GF_ORDER;
      if (ee < 0) ee = ee + GF_ORDER;
      res  = gf_elem_t'(1);
      base = gf_elem_t'(2);
      for (int i = 0; i < BCH_M; i++) begin
         if (ee[i]) res = gf_mul(res, base);
         base = gf_mul(base, base);
      end
      return res;
   endfunction

   // Exponent of alpha^-n written as a non-negative power: alpha^(1023-n).
   function automatic int gf_neg_exp(int n);
      return (GF_ORDER - (n % GF_ORDER)) % GF_ORDER;
   endfunction

   // x * alpha^e; e is always an elaboration-time constant at the call sites.
   function automatic gf_elem_t gf_const_mul(gf_elem_t x, int e);
      return gf_mul(x, gf_pow_alpha(e));
   endfunction

   // Coefficients alpha^(-k*step) for k = 0..T.
   function automatic gf_vec_t gf_step_coefs(int step);
      gf_vec_t v;
      for (int k = 0; k <= BCH_T; k++) v[k] = gf_pow_alpha(gf_neg_exp(k * step));
      return v;
   endfunction

   function automatic logic [CNT_W-1:0] chunk_popcount(chunk_t v);
      logic [CNT_W-1:0] n;
      n = '0;
      for (int i = 0; i < BCH_P; i++) n = n + CNT_W'(v[i]);
      return n;
   endfunction

endpackage

// File: rtl/bch_chien_search_if.sv
// Handshake bundle of the Chien search stage.
//   in_valid/in_ready + locator0..3           : locator input from Berlekamp-Massey
//   out_valid/out_ready + out_chunk/out_idx,
//   out_last, root_cnt, uncorrectable         : error-pattern output stream
// master = upstream/downstream environment, slave = the Chien search block.
interface bch_chien_search_if;
   import bch_pkg::*;

   logic             in_valid;
   logic             in_ready;
   gf_elem_t         locator0;
   gf_elem_t         locator1;
   gf_elem_t         locator2;
   gf_elem_t         locator3;
   logic             out_valid;
   logic             out_ready;
   chunk_t           out_chunk;
   logic [IDX_W-1:0] out_idx;
   logic             out_last;
   logic [CNT_W-1:0] root_cnt;
   logic             uncorrectable;

   modport master (
      output in_valid, locator0, locator1, locator2, locator3, out_ready,
      input  in_ready, out_valid, out_chunk, out_idx, out_last, root_cnt, uncorrectable
   );

   modport slave (
      input  in_valid, locator0, locator1, locator2, locator3, out_ready,
      output in_ready, out_valid, out_chunk, out_idx, out_last, root_cnt, uncorrectable
   );

endinterface

// File: rtl/bch_chien_cell.sv
// One Chien evaluation lane.
//   r_i    : current r_k = Lambda_k * alpha^(-k*c*P), k = 0..T
//   zero_o : 1 when sum_k r_k * alpha^(-k*P_IDX) == 0, i.e. position c*P+P_IDX is a root
// Purely combinational; all multipliers are by constants.
module bch_chien_cell
   import bch_pkg::*;
#(
   parameter int P_IDX = 0
) (
   input  gf_vec_t r_i,
   output logic    zero_o
);

   localparam gf_vec_t COEF = gf_step_coefs(P_IDX);

   gf_elem_t sum;

   always_comb begin
      sum = '0;
      for (int k = 0; k <= BCH_T; k++) sum = sum ^ gf_mul(r_i[k], COEF[k]);
   end

   assign zero_o = (sum == '0);

endmodule

// File: rtl/bch_chien_search.sv
// Chien search stage of the BCH(542,512) decoder.
// Evaluates the error locator at alpha^-j for j = 0..541, P positions per cycle,
// and streams the error pattern as 68 P-bit chunks, ending with the root count
// and the uncorrectable flag.
//   clk : clock
//   rst : synchronous, active-high reset
//   bus : bch_chien_search_if.slave (locator input handshake, chunk output handshake)
module bch_chien_search
   import bch_pkg::*;
(
   input logic               clk,
   input logic               rst,
   bch_chien_search_if.slave bus
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BCH_CHUNKS - 1);

   state_e           state_q, state_d;
   gf_vec_t          r_q, r_d;
   logic [IDX_W-1:0] c_q, c_d;
   logic [CNT_W-1:0] acc_q, acc_d;
   logic [1:0]       deg_q, deg_d;
   logic             lam0_zero_q, lam0_zero_d;
   logic             out_valid_q, out_valid_d;
   chunk_t           out_chunk_q, out_chunk_d;
   logic             out_last_q, out_last_d;
   logic [CNT_W-1:0] root_cnt_q, root_cnt_d;
   logic             uncorr_q, uncorr_d;

   logic             load_chunk;   // a new chunk is computed from r_d/c_d
   logic             clear_out;    // last chunk handed off, return to idle
   chunk_t           hit;
   chunk_t           chunk_mask;

   // The lanes look at the next-state coefficients so that the registered
   // chunk lines up with the registered chunk index.
   for (genvar p = 0; p < BCH_P; p++) begin : g_cell
      bch_chien_cell #(.P_IDX(p)) u_cell (
         .r_i    (r_d),
         .zero_o (hit[p])
      );
   end

   // Next-state: FSM, coefficient stepping, chunk counter, root accumulator.
   always_comb begin
      // NOTE: every signal written here gets a default first so no path infers a latch.
      state_d     = state_q;
      r_d         = r_q;
      c_d         = c_q;
      acc_d       = acc_q;
      deg_d       = deg_q;
      lam0_zero_d = lam0_zero_q;
      out_valid_d = out_valid_q;
      load_chunk  = 1'b0;
      clear_out   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               r_d         = {bus.locator3, bus.locator2, bus.locator1, bus.locator0};
               deg_d       = (bus.locator3 != '0) ? 2'd3 :
                             (bus.locator2 != '0) ? 2'd2 :
                             (bus.locator1 != '0) ? 2'd1 : 2'd0;
               lam0_zero_d = (bus.locator0 == '0);
               c_d         = '0;
               acc_d       = '0;
               out_valid_d = 1'b1;
               load_chunk  = 1'b1;
               state_d     = ST_SEARCH;
            end
         end
         ST_SEARCH: begin
            // A stall (out_ready low) leaves every register untouched.
            if (bus.out_ready) begin
               if (out_last_q) begin
                  c_d         = '0;
                  out_valid_d = 1'b0;
                  clear_out   = 1'b1;
                  state_d     = ST_IDLE;
               end else begin
                  // Advance every lane by P positions: r_k *= alpha^(-k*P).
                  for (int k = 0; k <= BCH_T; k++)
                     r_d[k] = gf_const_mul(r_q[k], gf_neg_exp(k * BCH_P));
                  c_d        = c_q + 1'b1;
                  acc_d      = acc_q + chunk_popcount(out_chunk_q);
                  load_chunk = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Next output values: masked chunk, last flag, final count and verdict.
   always_comb begin
      chunk_mask = '0;
      for (int p = 0; p < BCH_P; p++)
         chunk_mask[p] = hit[p] && ((int'(c_d) * BCH_P + p) < BCH_N);

      out_chunk_d = out_chunk_q;
      out_last_d  = out_last_q;
      root_cnt_d  = root_cnt_q;
      uncorr_d    = uncorr_q;

      if (clear_out) begin
         out_chunk_d = '0;
         out_last_d  = 1'b0;
         root_cnt_d  = '0;
         uncorr_d    = 1'b0;
      end else if (load_chunk) begin
         out_chunk_d = chunk_mask;
         out_last_d  = (c_d == LAST_IDX);
         root_cnt_d  = out_last_d ? (acc_d + chunk_popcount(chunk_mask)) : '0;
         // Lambda_0 == 0 also covers the all-zero locator.
         uncorr_d    = out_last_d && (lam0_zero_d || (root_cnt_d != CNT_W'(deg_d)));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         r_q         <= '0;
         c_q         <= '0;
         acc_q       <= '0;
         deg_q       <= '0;
         lam0_zero_q <= 1'b0;
         out_valid_q <= 1'b0;
         out_chunk_q <= '0;
         out_last_q  <= 1'b0;
         root_cnt_q  <= '0;
         uncorr_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q     <= state_d;
         r_q         <= r_d;
         c_q         <= c_d;
         acc_q       <= acc_d;
         deg_q       <= deg_d;
         lam0_zero_q <= lam0_zero_d;
         out_valid_q <= out_valid_d;
         out_chunk_q <= out_chunk_d;
         out_last_q  <= out_last_d;
         root_cnt_q  <= root_cnt_d;
         uncorr_q    <= uncorr_d;
      end
   end

   assign bus.in_ready      = (state_q == ST_IDLE);
   assign bus.out_valid     = out_valid_q;
   assign bus.out_chunk     = out_chunk_q;
   assign bus.out_idx       = c_q;
   assign bus.out_last      = out_last_q;
   assign bus.root_cnt      = root_cnt_q;
   assign bus.uncorrectable = uncorr_q;

endmodule
